led_fader: RTL and testbench
============================

LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 Parameter LED_CNT, default 3: number of RGB LEDs; the colour image is LED_CNT*3 bytes (NBYTES).
REQ-002 Parameter CLK_SPEED, default 25_000_000: clk frequency in Hz.
REQ-003 Parameter STEP_HZ, default 1000: fade step rate in Hz; TICK_DIV = CLK_SPEED/STEP_HZ (integer division).
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately, release is taken on a clk edge.
REQ-006 target_i  input  LED_CNT*24  colour image from the I2C register stage; byte k = bits [8k+7:8k].
REQ-007 fade_en_i  input  1  1 = ramp data_o toward target_i; 0 = data_o tracks target_i directly.
REQ-008 data_o  output  LED_CNT*24  registered colour image fed to the LED serializer; same byte layout as target_i.
REQ-009 busy_o  output  1  combinational; 1 whenever data_o != target_i.
REQ-010 step_done_o  output  1  registered one-cycle pulse at the end of every completed scan.

Function
REQ-011 Compile-time constraint: TICK_DIV >= NBYTES+2; the elaboration check rejects smaller values.
REQ-012 Prescaler: free-running counter 0..TICK_DIV-1, wraps to 0; tick = 1 for the cycle where the counter equals TICK_DIV-1.
REQ-013 FSM states: IDLE, SCAN.
REQ-014 IDLE: on tick with fade_en_i=1 -> SCAN with byte index idx=0; otherwise stay.
REQ-015 SCAN: one byte per cycle; at idx, if data byte < target byte then +1, if > then -1, if equal then unchanged; the comparison uses target_i sampled in that same cycle.
REQ-016 SCAN at idx=NBYTES-1: update byte, pulse step_done_o on the next cycle, return to IDLE; one scan takes exactly NBYTES cycles.
REQ-017 Each byte changes by at most 1 per scan; a full 0->255 ramp takes 255 ticks; byte arithmetic never wraps (no 255->0 or 0->255).
REQ-018 fade_en_i=0, any state: all of data_o loads target_i on the next edge, FSM -> IDLE, idx -> 0, no step_done_o pulse; an in-progress scan is aborted.
REQ-019 Tick while in SCAN is dropped (unreachable under REQ-011); the prescaler never stalls.
REQ-020 target_i changing mid-scan: bytes already visited keep their value; remaining bytes step toward the new value.
REQ-021 A scan still executes when data_o == target_i (all bytes unchanged) and still pulses step_done_o.
REQ-022 idx width = clog2(NBYTES) (minimum 1); idx never exceeds NBYTES-1.

Reset
REQ-023 reset=0 asynchronously sets data_o=0, step_done_o=0, prescaler=0, idx=0, FSM=IDLE.
REQ-024 Reset asserted mid-scan discards the scan; after release the first tick occurs TICK_DIV cycles later.
REQ-025 busy_o during reset reflects target_i != 0.

Verification (LED_CNT=3, CLK_SPEED=1000, STEP_HZ=100 -> TICK_DIV=10, NBYTES=9)
REQ-026 Reset, target_i=0, fade_en_i=1 -> data_o=0, busy_o=0; step_done_o pulses once every 10 cycles.
REQ-027 fade_en_i=0, target_i=0x112233_445566_778899 -> data_o equals it one edge later; busy_o=0; no step_done_o.
REQ-028 fade_en_i=1, from 0, byte 0 target 0x03 -> byte 0 reads 1, 2, 3 after ticks 1-3, then holds 3; busy_o falls after the third scan.
REQ-029 data_o byte 4 = 0x05, target byte 4 = 0x02 -> decrements to 0x02 in 3 scans; byte 4 changes exactly 5 cycles after the tick; no underflow.
REQ-030 Mid-scan (idx=4), fade_en_i drops to 0 -> next edge data_o == target_i, FSM IDLE, no step_done_o; re-enabled scan starts at idx 0.
REQ-031 Mid-scan, reset pulsed low for 1 cycle -> data_o=0 immediately; after release the first tick is 10 cycles later, then the scan runs normally.

Source files
------------

// File: rtl/led_fader.sv
// LED colour fader: ramps a registered RGB image toward the target image by one
// LSB per byte per fade tick, visiting one byte per clock during a scan.
module led_fader #(
    parameter int LED_CNT   = 3,
    parameter int CLK_SPEED = 25_000_000,
    parameter int STEP_HZ   = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LED_CNT*24-1:0]  target_i,
    input  logic                   fade_en_i,
    output logic [LED_CNT*24-1:0]  data_o,
    output logic                   busy_o,
    output logic                   step_done_o
);

    localparam int NBYTES   = LED_CNT * 3;
    localparam int TICK_DIV = CLK_SPEED / STEP_HZ;
    localparam int IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);

    // A scan must finish before the next tick arrives.
    generate
        if (TICK_DIV < NBYTES + 2) begin : g_bad_tick_div
            $error("led_fader: TICK_DIV (%0d) must be >= NBYTES+2 (%0d)", TICK_DIV, NBYTES + 2);
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               step_done_q, step_done_d;
    logic               tick;
    logic               scan_en;

    // Free-running prescaler; never stalls, regardless of FSM state.
    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        step_done_d = 1'b0;
        scan_en     = 1'b0;
        if (!fade_en_i) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        state_d = SCAN;
                        idx_d   = '0;
                    end
                end
                SCAN: begin
                    scan_en = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d     = IDLE;
                        idx_d       = '0;
                        step_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            step_done_q <= step_done_d;
        end
    end

    // One saturating up/down byte per colour channel; only the byte under idx moves.
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
        logic [7:0] byte_q, byte_d;
        logic [7:0] tgt_b;

        assign tgt_b = target_i[8*gi +: 8];

        always_comb begin
            byte_d = byte_q;
            if (!fade_en_i) begin
                byte_d = tgt_b;
            end else if (scan_en && (idx_q == IDX_W'(gi))) begin
                if (byte_q < tgt_b) begin
                    byte_d = byte_q + 8'd1;
                end else if (byte_q > tgt_b) begin
                    byte_d = byte_q - 8'd1;
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                byte_q <= 8'd0;
            end else begin
                byte_q <= byte_d;
            end
        end

        assign data_o[8*gi +: 8] = byte_q;
    end

    assign busy_o      = (data_o != target_i);
    assign step_done_o = step_done_q;

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader: directed vector table, hand-written corner
// sequences, and a randomized run compared cycle-by-cycle to a reference model.
module tb_led_fader;

    localparam int LED_CNT   = 3;
    localparam int CLK_SPEED = 1000;
    localparam int STEP_HZ   = 100;
    localparam int TICK_DIV  = CLK_SPEED / STEP_HZ;
    localparam int NBYTES    = LED_CNT * 3;
    localparam int W         = LED_CNT * 24;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] target_i;
    logic         fade_en_i;
    logic [W-1:0] data_o;
    logic         busy_o;
    logic         step_done_o;

    int n_checks  = 0;
    int n_fail    = 0;
    int since_rst = 0;
    int done_seen = 0;

    // Reference model: byte image, scan position (-1 = not scanning), tick phase.
    logic [7:0] m_data [NBYTES];
    int         m_scan;
    int         m_phase;
    logic       m_done;

    typedef struct {
        logic [W-1:0] tgt;
        logic         en;
        int           cycles;
        logic [W-1:0] exp_data;
        logic         exp_busy;
        int           exp_dones;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    led_fader #(
        .LED_CNT   (LED_CNT),
        .CLK_SPEED (CLK_SPEED),
        .STEP_HZ   (STEP_HZ)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .target_i    (target_i),
        .fade_en_i   (fade_en_i),
        .data_o      (data_o),
        .busy_o      (busy_o),
        .step_done_o (step_done_o)
    );

    function automatic logic [W-1:0] m_image();
        logic [W-1:0] v;
        v = '0;
        for (int b = 0; b < NBYTES; b++) v[8*b +: 8] = m_data[b];
        return v;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NBYTES; b++) m_data[b] = 8'd0;
        m_scan  = -1;
        m_phase = 0;
        m_done  = 1'b0;
    endtask

    // Applies one rising edge worth of behaviour, using the inputs seen at that edge.
    task automatic model_edge();
        bit         tick;
        logic [7:0] t;
        tick    = (m_phase == TICK_DIV - 1);
        m_phase = (m_phase + 1) % TICK_DIV;
        m_done  = 1'b0;
        if (!fade_en_i) begin
            for (int b = 0; b < NBYTES; b++) m_data[b] = target_i[8*b +: 8];
            m_scan = -1;
        end else if (m_scan >= 0) begin
            t = target_i[8*m_scan +: 8];
            if (m_data[m_scan] < t) m_data[m_scan] = m_data[m_scan] + 8'd1;
            else if (m_data[m_scan] > t) m_data[m_scan] = m_data[m_scan] - 8'd1;
            if (m_scan == NBYTES - 1) begin
                m_done = 1'b1;
                m_scan = -1;
            end else begin
                m_scan = m_scan + 1;
            end
        end else if (tick) begin
            m_scan = 0;
        end
    endtask

    task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d: got %h expected %h", name, since_rst, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d: got %b expected %b", name, since_rst, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d: got %0d expected %0d", name, since_rst, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        since_rst++;
        if (step_done_o) done_seen++;
        check_vec("model_data", data_o, m_image());
        check_bit("model_busy", busy_o, m_image() != target_i);
        check_bit("model_done", step_done_o, m_done);
    endtask

    task automatic run_until(input int edge_no);
        while (since_rst < edge_no) step();
    endtask

    // Called just after an edge: asserts reset mid-cycle for one edge, then releases.
    task automatic pulse_reset();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_vec("reset_data", data_o, '0);
        check_bit("reset_done", step_done_o, 1'b0);
        check_bit("reset_busy", busy_o, target_i != '0);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        since_rst = 0;
    endtask

    initial begin
        vecs[0] = '{72'h0,                    1'b1, 30, 72'h0,                    1'b0, 2};
        vecs[1] = '{72'h112233445566778899,   1'b0, 1,  72'h112233445566778899,   1'b0, 0};
        vecs[2] = '{72'h0,                    1'b0, 1,  72'h0,                    1'b0, 0};
        vecs[3] = '{72'h3,                    1'b1, 9,  72'h1,                    1'b1, 0};
        vecs[4] = '{72'h3,                    1'b1, 10, 72'h2,                    1'b1, 1};
        vecs[5] = '{72'h3,                    1'b1, 10, 72'h3,                    1'b0, 1};
        vecs[6] = '{72'h3,                    1'b1, 20, 72'h3,                    1'b0, 2};

        reset     = 1'b0;
        target_i  = '0;
        fade_en_i = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_vec("rst_data", data_o, '0);
        check_bit("rst_busy", busy_o, 1'b0);
        check_bit("rst_done", step_done_o, 1'b0);
        target_i = 72'h5;
        #1;
        check_bit("rst_busy_tgt", busy_o, 1'b1);
        target_i  = '0;
        reset     = 1'b1;
        since_rst = 0;

        for (int v = 0; v < 7; v++) begin
            target_i  = vecs[v].tgt;
            fade_en_i = vecs[v].en;
            done_seen = 0;
            repeat (vecs[v].cycles) step();
            check_vec("vec_data", data_o, vecs[v].exp_data);
            check_bit("vec_busy", busy_o, vecs[v].exp_busy);
            check_int("vec_dones", done_seen, vecs[v].exp_dones);
        end

        // Decrement of byte 4 from 5 to 2, lands 5 edges after the scan starts.
        fade_en_i = 1'b0;
        target_i  = 72'h05_0000_0000;
        step();
        fade_en_i = 1'b1;
        target_i  = 72'h02_0000_0000;
        run_until(94);
        check_int("dec_pre", int'(data_o[39:32]), 5);
        step();
        check_int("dec_1", int'(data_o[39:32]), 4);
        run_until(104);
        check_int("dec_hold", int'(data_o[39:32]), 4);
        step();
        check_int("dec_2", int'(data_o[39:32]), 3);
        run_until(115);
        check_int("dec_3", int'(data_o[39:32]), 2);
        run_until(125);
        check_int("dec_floor", int'(data_o[39:32]), 2);
        check_bit("dec_busy", busy_o, 1'b0);

        // Abort at idx 4, then a fresh scan must restart at byte 0.
        target_i = {NBYTES{8'h80}};
        run_until(134);
        fade_en_i = 1'b0;
        done_seen = 0;
        step();
        check_vec("abort_data", data_o, {NBYTES{8'h80}});
        check_bit("abort_busy", busy_o, 1'b0);
        run_until(137);
        fade_en_i = 1'b1;
        target_i  = {NBYTES{8'h81}};
        run_until(141);
        check_vec("restart_idx0", data_o, 72'h808080808080808081);
        check_int("abort_no_done", done_seen, 0);
        run_until(149);
        check_vec("restart_full", data_o, {NBYTES{8'h81}});
        check_bit("restart_done", step_done_o, 1'b1);

        // Reset pulse mid-scan; first tick lands TICK_DIV edges after release.
        target_i = {NBYTES{8'h90}};
        run_until(153);
        pulse_reset();
        run_until(10);
        check_vec("post_rst_wait", data_o, '0);
        step();
        check_vec("post_rst_first", data_o, 72'h01);
        run_until(19);
        check_vec("post_rst_scan", data_o, {NBYTES{8'h01}});
        check_bit("post_rst_done", step_done_o, 1'b1);

        // Randomized run against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                for (int b = 0; b < NBYTES; b++)
                    target_i[8*b +: 8] = ($urandom_range(0, 1) == 1) ?
                        8'($urandom_range(0, 12)) : 8'($urandom_range(244, 255));
            end
            fade_en_i = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 599) == 0) pulse_reset();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
